// File: rtl/sync_fifo_pkg.sv
// Shared widths and default thresholds for the flexible-depth synchronous FIFO.
package sync_fifo_pkg;

    localparam int DEF_AE_LEVEL  = 2;
    localparam int DEF_AF_MARGIN = 2;

    // Pointer width; never below 1 so a DEPTH of 2 still gets a real bit.
    function automatic int ptr_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sfifo_ram.sv
// Storage for sync_fifo_flex: one write port and a registered read port.
module sfifo_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read register sees the pre-write word when both ports hit the same entry.
    always_ff @(posedge CLK) begin
        if (RST)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO of arbitrary depth with fill count and threshold flags.
// Sticky OVERFLOW/UNDERFLOW flags are built only when SYNC_FIFO_ERR_EN is defined.
module sync_fifo_flex
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - DEF_AF_MARGIN,
    parameter int AE_LEVEL   = DEF_AE_LEVEL
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      W_INC,
    input  logic [DATA_WIDTH-1:0]     WR_DATA,
    input  logic                      R_INC,
    input  logic                      ERR_CLR,
    output logic [DATA_WIDTH-1:0]     RD_DATA,
    output logic                      RD_VALID,
    output logic                      FULL,
    output logic                      EMPTY,
    output logic                      ALMOST_FULL,
    output logic                      ALMOST_EMPTY,
    output logic [cnt_w(DEPTH)-1:0]   COUNT,
    output logic                      OVERFLOW,
    output logic                      UNDERFLOW
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_acc;
    logic             rd_acc;

    assign rd_acc = R_INC & ~EMPTY;
    assign wr_acc = W_INC & (~FULL | rd_acc);

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            COUNT    <= '0;
            RD_VALID <= 1'b0;
        end else begin
            RD_VALID <= rd_acc;
            if (wr_acc)
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (rd_acc)
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            unique case ({wr_acc, rd_acc})
                2'b10:   COUNT <= COUNT + 1'b1;
                2'b01:   COUNT <= COUNT - 1'b1;
                default: COUNT <= COUNT;
            endcase
        end
    end

    assign EMPTY        = (COUNT == '0);
    assign FULL         = (COUNT == CNT_W'(DEPTH));
    assign ALMOST_FULL  = (COUNT >= CNT_W'(AF_LEVEL));
    assign ALMOST_EMPTY = (COUNT <= CNT_W'(AE_LEVEL));

    sfifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_ram (
        .CLK   (CLK),
        .RST   (RST),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (WR_DATA),
        .re    (rd_acc),
        .raddr (rd_ptr),
        .rdata (RD_DATA)
    );

`ifdef SYNC_FIFO_ERR_EN
    // A new error in the clearing cycle keeps its flag set.
    always_ff @(posedge CLK) begin
        if (RST) begin
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            OVERFLOW  <= (W_INC & ~wr_acc) | (OVERFLOW  & ~ERR_CLR);
            UNDERFLOW <= (R_INC & EMPTY)   | (UNDERFLOW & ~ERR_CLR);
        end
    end
`else
    logic err_clr_unused;
    assign err_clr_unused = ERR_CLR;
    assign OVERFLOW       = 1'b0;
    assign UNDERFLOW      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Self-checking bench for sync_fifo_flex: queue-based reference model plus directed scenarios.
module tb_sync_fifo_flex;

    localparam int DW    = 16;
    localparam int DEPTH = 6;
    localparam int AF    = 5;
    localparam int AE    = 1;
`ifdef SYNC_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          CLK;
    logic          RST;
    logic          W_INC;
    logic [DW-1:0] WR_DATA;
    logic          R_INC;
    logic          ERR_CLR;
    logic [DW-1:0] RD_DATA;
    logic          RD_VALID;
    logic          FULL;
    logic          EMPTY;
    logic          ALMOST_FULL;
    logic          ALMOST_EMPTY;
    logic [2:0]    COUNT;
    logic          OVERFLOW;
    logic          UNDERFLOW;

    sync_fifo_flex #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .W_INC        (W_INC),
        .WR_DATA      (WR_DATA),
        .R_INC        (R_INC),
        .ERR_CLR      (ERR_CLR),
        .RD_DATA      (RD_DATA),
        .RD_VALID     (RD_VALID),
        .FULL         (FULL),
        .EMPTY        (EMPTY),
        .ALMOST_FULL  (ALMOST_FULL),
        .ALMOST_EMPTY (ALMOST_EMPTY),
        .COUNT        (COUNT),
        .OVERFLOW     (OVERFLOW),
        .UNDERFLOW    (UNDERFLOW)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue holding the FIFO contents in order.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rd_data = '0;
    bit            m_rd_valid = 1'b0;
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;

    always @(posedge CLK) begin
        int  sz;
        bit  rd_ok;
        bit  wr_ok;
        if (RST) begin
            q.delete();
            m_rd_data  = '0;
            m_rd_valid = 1'b0;
            m_ovf      = 1'b0;
            m_unf      = 1'b0;
        end else begin
            sz    = q.size();
            rd_ok = R_INC && (sz > 0);
            wr_ok = W_INC && ((sz < DEPTH) || rd_ok);
            m_rd_valid = rd_ok;
            if (rd_ok) m_rd_data = q.pop_front();
            if (wr_ok) q.push_back(WR_DATA);
            if (ERR_EN) begin
                if (ERR_CLR) begin
                    m_ovf = 1'b0;
                    m_unf = 1'b0;
                end
                if (W_INC && !wr_ok) m_ovf = 1'b1;
                if (R_INC && sz == 0) m_unf = 1'b1;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("count",     32'(COUNT),        32'(q.size()));
            chk("empty",     32'(EMPTY),        32'(q.size() == 0));
            chk("full",      32'(FULL),         32'(q.size() == DEPTH));
            chk("alm_full",  32'(ALMOST_FULL),  32'(q.size() >= AF));
            chk("alm_empty", 32'(ALMOST_EMPTY), 32'(q.size() <= AE));
            chk("rd_valid",  32'(RD_VALID),     32'(m_rd_valid));
            chk("rd_data",   32'(RD_DATA),      32'(m_rd_data));
            chk("overflow",  32'(OVERFLOW),     32'(m_ovf));
            chk("underflow", 32'(UNDERFLOW),    32'(m_unf));
        end
    end

    // Drive one cycle's inputs at a falling edge and return at the next one.
    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r,
                       input logic c, input logic rs);
        W_INC   = w;
        WR_DATA = d;
        R_INC   = r;
        ERR_CLR = c;
        RST     = rs;
        @(negedge CLK);
    endtask

    initial begin
        W_INC = 0; WR_DATA = '0; R_INC = 0; ERR_CLR = 0; RST = 1;
        @(negedge CLK);
        cyc(1, 16'hFFFF, 1, 0, 1);
        chk_en = 1'b1;
        chk("rst_count", 32'(COUNT), 0);
        chk("rst_empty", 32'(EMPTY), 1);
        chk("rst_ae",    32'(ALMOST_EMPTY), 1);
        chk("rst_full",  32'(FULL), 0);
        chk("rst_af",    32'(ALMOST_FULL), 0);
        chk("rst_rdv",   32'(RD_VALID), 0);
        chk("rst_rdd",   32'(RD_DATA), 0);
        chk("rst_ovf",   32'(OVERFLOW), 0);

        // Fill to full, then one dropped write.
        for (int k = 1; k <= 6; k++) begin
            cyc(1, DW'(k), 0, 0, 0);
            chk("fill_count", 32'(COUNT), 32'(k));
            chk("fill_af",    32'(ALMOST_FULL), 32'(k >= 5));
            chk("fill_ae",    32'(ALMOST_EMPTY), 32'(k <= 1));
        end
        chk("fill_full", 32'(FULL), 1);
        cyc(1, 16'h0007, 0, 0, 0);
        chk("ovf_count", 32'(COUNT), 6);
        chk("ovf_flag",  32'(OVERFLOW), 32'(ERR_EN));

        // Drain in order, then one read on empty.
        for (int k = 1; k <= 6; k++) begin
            cyc(0, 0, 1, 0, 0);
            chk("drain_valid", 32'(RD_VALID), 1);
            chk("drain_data",  32'(RD_DATA), 32'(k));
        end
        chk("drain_empty", 32'(EMPTY), 1);
        cyc(0, 0, 1, 0, 0);
        chk("unf_valid", 32'(RD_VALID), 0);
        chk("unf_flag",  32'(UNDERFLOW), 32'(ERR_EN));
        chk("unf_hold",  32'(RD_DATA), 6);
        cyc(0, 0, 0, 1, 0);
        chk("clr_ovf", 32'(OVERFLOW), 0);
        chk("clr_unf", 32'(UNDERFLOW), 0);

        // Stream 20 words through a one-deep prefill; crosses the pointer wrap several times.
        cyc(1, 16'h0100, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1, DW'(16'h0101 + i), 1, 0, 0);
            chk("strm_count", 32'(COUNT), 1);
            chk("strm_data",  32'(RD_DATA), 32'(16'h0100 + i));
        end
        cyc(0, 0, 1, 0, 0);
        chk("strm_last", 32'(RD_DATA), 32'h0114);

        // Simultaneous write and read while full.
        for (int k = 0; k < 6; k++) cyc(1, DW'(16'h0010 + k), 0, 0, 0);
        cyc(1, 16'h00AA, 1, 0, 0);
        chk("fullrw_count", 32'(COUNT), 6);
        chk("fullrw_data",  32'(RD_DATA), 32'h0010);
        for (int k = 0; k < 6; k++) cyc(0, 0, 1, 0, 0);
        chk("fullrw_aa", 32'(RD_DATA), 32'h00AA);

        // Simultaneous write and read while empty: read must be refused.
        cyc(1, 16'h0055, 1, 0, 0);
        chk("emptyrw_count", 32'(COUNT), 1);
        chk("emptyrw_valid", 32'(RD_VALID), 0);
        chk("emptyrw_unf",   32'(UNDERFLOW), 32'(ERR_EN));
        cyc(0, 0, 1, 0, 0);
        chk("emptyrw_data", 32'(RD_DATA), 32'h0055);

        // Reset with four words stored and a pending error.
        cyc(0, 0, 1, 0, 0);
        for (int k = 0; k < 4; k++) cyc(1, DW'(16'h0021 + k), 0, 0, 0);
        chk("prerst_count", 32'(COUNT), 4);
        cyc(1, 16'h0099, 1, 0, 1);
        chk("midrst_count", 32'(COUNT), 0);
        chk("midrst_empty", 32'(EMPTY), 1);
        chk("midrst_unf",   32'(UNDERFLOW), 0);
        cyc(1, 16'h0077, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("postrst_data", 32'(RD_DATA), 32'h0077);
        cyc(0, 0, 1, 0, 0);
        chk("postrst_empty", 32'(EMPTY), 1);

        // Randomised traffic with phases biased toward full and toward empty.
        for (int i = 0; i < 3000; i++) begin
            int pw;
            pw = ((i / 150) % 2 == 0) ? 75 : 30;
            cyc($urandom_range(0, 99) < pw,
                DW'($urandom),
                $urandom_range(0, 99) < (100 - pw),
                $urandom_range(0, 15) == 0,
                $urandom_range(0, 299) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
